// File: rtl/bfu_pkg.sv
// Shared types and arithmetic helpers for the butterfly unit.
// Helpers work on a 32-bit word so any coefficient width up to 32 can use them;
// callers widen their operands with a cast and narrow the result again.
package bfu_pkg;

  typedef enum logic [1:0] {
    BF_CT     = 2'd0,
    BF_GS     = 2'd1,
    BF_ADDSUB = 2'd2,
    BF_MUL    = 2'd3
  } bf_mode_t;

  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  // Barrett constant M = floor(2^(2*cw) / q)
  function automatic longint unsigned barrett_m(input int cw, input int q);
    longint unsigned num;
    num = 64'd1 << (2 * cw);
    return num / 64'(q);
  endfunction

  // (x + y) mod q for x, y already in [0, q)
  function automatic word_t modadd(input word_t x, input word_t y, input word_t q);
    logic [WORD_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return word_t'(s);
  endfunction

  // (x - y) mod q for x, y already in [0, q)
  function automatic word_t modsub(input word_t x, input word_t y, input word_t q);
    word_t d;
    if (x >= y) d = x - y;
    else        d = x + q - y;
    return d;
  endfunction

  // x / 2 mod q for odd q: odd values borrow one q before shifting
  function automatic word_t half_mod(input word_t x, input word_t q);
    logic [WORD_W:0] t;
    t = x[0] ? ({1'b0, x} + {1'b0, q}) : {1'b0, x};
    return word_t'(t >> 1);
  endfunction

endpackage

// File: rtl/modmul_barrett.sv
// Pipelined modular multiplier: p = x*y mod Q after MUL_LAT enabled cycles.
// With MUL_LAT > 1 the raw product gets its own register stage, the Barrett
// reduction follows, and any further stages are plain delay registers.
module modmul_barrett
  import bfu_pkg::*;
#(
  parameter int CW      = 12,
  parameter int Q       = 3329,
  parameter int MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  output logic [CW-1:0] p
);

  localparam int              PW    = 2 * CW;
  localparam longint unsigned M_VAL = barrett_m(CW, Q);
  localparam int              MW    = $clog2(M_VAL + 1);
  localparam int              XW    = PW + MW;
  localparam logic [MW-1:0]   M_C   = MW'(M_VAL);
  localparam logic [PW-1:0]   Q_P   = PW'(Q);
  localparam int              DLY   = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

  logic [PW-1:0] prod_c;
  logic [PW-1:0] red_in;
  logic [XW-1:0] prod_m;
  logic [MW-1:0] qhat;
  logic [PW-1:0] q_est;
  logic [PW-1:0] rem0;
  logic [PW-1:0] rem1;
  logic [PW-1:0] rem2;
  logic [CW-1:0] res_c;
  logic [CW-1:0] dly_q [DLY];

  assign prod_c = PW'(x) * PW'(y);

  generate
    if (MUL_LAT > 1) begin : g_prod_reg
      logic [PW-1:0] prod_q;
      // Raw product register so the reduction has a full cycle to itself
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     prod_q <= '0;
        else if (en) prod_q <= prod_c;
      end
      assign red_in = prod_q;
    end else begin : g_prod_comb
      assign red_in = prod_c;
    end
  endgenerate

  // Barrett estimate leaves a remainder below 3Q, so two corrections suffice
  always_comb begin
    prod_m = XW'(red_in) * XW'(M_C);
    qhat   = MW'(prod_m >> PW);
    q_est  = PW'(qhat) * Q_P;
    rem0   = red_in - q_est;
    rem1   = (rem0 >= Q_P) ? rem0 - Q_P : rem0;
    rem2   = (rem1 >= Q_P) ? rem1 - Q_P : rem1;
    res_c  = CW'(rem2);
  end

  // Reduced result register followed by any extra balancing stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DLY; i++) dly_q[i] <= '0;
    end else if (en) begin
      dly_q[0] <= res_c;
      for (int i = 1; i < DLY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign p = dly_q[DLY-1];

endmodule

// File: rtl/bfu_pipe.sv
// Butterfly unit (CT, GS, ADDSUB, MUL) with valid/ready flow control.
// Every mode walks the same MUL_LAT+2 stages so results leave in issue order;
// a single enable freezes the whole pipe while the output beat is not taken.
module bfu_pipe
  import bfu_pkg::*;
#(
  parameter int CW       = 12,
  parameter int Q        = 3329,
  parameter int MUL_LAT  = 2,
  parameter int GS_HALVE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic [CW-1:0] w,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    mode_out,
  output logic [CW-1:0] e,
  output logic [CW-1:0] o
);

  localparam word_t         Q_W  = word_t'(Q);
  localparam logic [CW-1:0] Q_C  = CW'(Q);
  localparam int            LAST = MUL_LAT - 1;

  logic          en;
  bf_mode_t      mode_in;
  logic [CW-1:0] pre_add;
  logic [CW-1:0] pre_sub;
  logic [CW-1:0] mul_x;

  logic          s1_valid;
  bf_mode_t      s1_mode;
  logic [CW-1:0] s1_a;
  logic [CW-1:0] s1_add;
  logic [CW-1:0] s1_sub;
  logic [CW-1:0] s1_x;
  logic [CW-1:0] s1_w;

  logic          mv   [MUL_LAT];
  bf_mode_t      mm   [MUL_LAT];
  logic [CW-1:0] ma   [MUL_LAT];
  logic [CW-1:0] madd [MUL_LAT];
  logic [CW-1:0] msub [MUL_LAT];

  logic [CW-1:0] prod;
  logic [CW-1:0] fin_e;
  logic [CW-1:0] fin_o;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign mode_in  = bf_mode_t'(mode);

  // Pre-add/sub for GS and ADDSUB, and the multiplier operand choice
  always_comb begin
    pre_add = CW'(modadd(word_t'(a), word_t'(b), Q_W));
    pre_sub = CW'(modsub(word_t'(a), word_t'(b), Q_W));
    mul_x   = (mode_in == BF_GS) ? pre_sub : b;
  end

  // S1: capture the beat (a bubble when in_valid is low)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= BF_CT;
      s1_a     <= '0;
      s1_add   <= '0;
      s1_sub   <= '0;
      s1_x     <= '0;
      s1_w     <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_mode  <= mode_in;
      s1_a     <= a;
      s1_add   <= pre_add;
      s1_sub   <= pre_sub;
      s1_x     <= mul_x;
      s1_w     <= w;
    end
  end

  modmul_barrett #(
    .CW      (CW),
    .Q       (Q),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .x   (s1_x),
    .y   (s1_w),
    .p   (prod)
  );

  // Side-band chain that travels alongside the multiplier stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        mv[i]   <= 1'b0;
        mm[i]   <= BF_CT;
        ma[i]   <= '0;
        madd[i] <= '0;
        msub[i] <= '0;
      end
    end else if (en) begin
      mv[0]   <= s1_valid;
      mm[0]   <= s1_mode;
      ma[0]   <= s1_a;
      madd[0] <= s1_add;
      msub[0] <= s1_sub;
      for (int i = 1; i < MUL_LAT; i++) begin
        mv[i]   <= mv[i-1];
        mm[i]   <= mm[i-1];
        ma[i]   <= ma[i-1];
        madd[i] <= madd[i-1];
        msub[i] <= msub[i-1];
      end
    end
  end

  // Final stage: CT add/sub against the product, GS halving, result select
  always_comb begin
    fin_e = '0;
    fin_o = '0;
    case (mm[LAST])
      BF_CT: begin
        fin_e = CW'(modadd(word_t'(ma[LAST]), word_t'(prod), Q_W));
        fin_o = CW'(modsub(word_t'(ma[LAST]), word_t'(prod), Q_W));
      end
      BF_GS: begin
        if (GS_HALVE != 0) begin
          fin_e = CW'(half_mod(word_t'(madd[LAST]), Q_W));
          fin_o = CW'(half_mod(word_t'(prod), Q_W));
        end else begin
          fin_e = madd[LAST];
          fin_o = prod;
        end
      end
      BF_ADDSUB: begin
        fin_e = madd[LAST];
        fin_o = msub[LAST];
      end
      default: begin
        fin_e = prod;
        fin_o = '0;
      end
    endcase
  end

  // Output register, held while the downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      mode_out  <= 2'd0;
      e         <= '0;
      o         <= '0;
    end else if (en) begin
      out_valid <= mv[LAST];
      mode_out  <= mm[LAST];
      e         <= fin_e;
      o         <= fin_o;
    end
  end

  // Operands must already be reduced below Q
  assert property (@(posedge clk) disable iff (rst)
    in_valid |-> (a < Q_C && b < Q_C && w < Q_C));

endmodule
